dm_store_buffer: RTL and testbench

// - Posted store buffer between the pipeline CPU's MEM stage and the byte-wide data memory (128 x 8b).
// - Accepts word stores in one cycle.
// - Drains each store to memory one byte per cycle, little-endian.
// - Forwards buffered data to word loads so the pipeline always sees program-order memory contents.

---
 rtl/dm_store_buffer_pkg.sv | 32 +++
 rtl/dm_store_buffer_if.sv | 42 ++++
 rtl/dm_store_buffer_drain.sv | 64 ++++++
 rtl/dm_store_buffer.sv | 137 +++++++++++++
 tb/tb_dm_store_buffer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_store_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dm_sb_pkg                                              |
// | Description : Shared types and constants for the posted store        |
// |               buffer (entry layout, drain state, byte helpers).      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package dm_sb_pkg;

  localparam int SB_BYTES_PER_WORD = 4;
  localparam int SB_ADDR_W         = 7;
  // Entries hold word addresses only; the byte offset comes from the drain counter.
  localparam int SB_WADDR_W        = SB_ADDR_W - 2;

  typedef enum logic [0:0] {
    SB_IDLE  = 1'b0,
    SB_DRAIN = 1'b1
  } sb_state_t;

  typedef struct packed {
    logic                  valid;
    logic [SB_WADDR_W-1:0] waddr;
    logic [31:0]           data;
  } sb_entry_t;

  // Little-endian byte lane select of a 32-bit word.
  function automatic logic [7:0] sb_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_store_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dm_store_buffer_if                                     |
// | Description : MEM-stage store/load port plus byte-wide memory write  |
// |               port of the store buffer.                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface dm_store_buffer_if #(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 3
);

  logic              st_valid_i;
  logic [31:0]       st_addr_i;
  logic [31:0]       st_data_i;
  logic              st_ready_o;
  logic [31:0]       ld_addr_i;
  logic [31:0]       ld_mem_data_i;
  logic [31:0]       ld_data_o;
  logic              ld_fwd_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_wdata_o;
  logic [CNT_W-1:0]  count_o;
  logic              empty_o;

  // Pipeline / memory side that talks to the buffer.
  modport master (
    output st_valid_i, st_addr_i, st_data_i, ld_addr_i, ld_mem_data_i,
    input  st_ready_o, ld_data_o, ld_fwd_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  count_o, empty_o
  );

  // The store buffer itself.
  modport slave (
    input  st_valid_i, st_addr_i, st_data_i, ld_addr_i, ld_mem_data_i,
    output st_ready_o, ld_data_o, ld_fwd_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output count_o, empty_o
  );

endinterface
`default_nettype wire

// File: rtl/dm_store_buffer_drain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dm_sb_drain_fsm                                        |
// | Description : Drains the head store entry to byte-wide memory, one  |
// |               byte per cycle little-endian, and pulses pop after     |
// |               the last byte.                                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dm_sb_drain_fsm
  import dm_sb_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_busy_nxt,
  input  logic [ADDR_W-3:0] i_head_waddr,
  input  logic [31:0]       i_head_data,
  output logic              o_pop,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata
);

  localparam int                 c_IDX_W    = $clog2(SB_BYTES_PER_WORD);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(SB_BYTES_PER_WORD - 1);

  sb_state_t          r_state;
  logic [c_IDX_W-1:0] r_byte_idx;
  logic               w_draining;

  // Enter DRAIN on the edge that leaves the buffer non-empty so the first
  // byte goes out in the very next cycle; byte_idx wraps naturally at 3.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= SB_IDLE;
      r_byte_idx <= '0;
    end else begin
      case (r_state)
        SB_IDLE: begin
          r_byte_idx <= '0;
          if (i_busy_nxt) r_state <= SB_DRAIN;
        end
        SB_DRAIN: begin
          r_byte_idx <= r_byte_idx + c_IDX_W'(1);
          if ((r_byte_idx == c_LAST_IDX) && !i_busy_nxt) r_state <= SB_IDLE;
        end
        default: begin
          r_state    <= SB_IDLE;
          r_byte_idx <= '0;
        end
      endcase
    end
  end

  assign w_draining  = (r_state == SB_DRAIN);
  assign o_pop       = w_draining && (r_byte_idx == c_LAST_IDX);
  assign o_mem_we    = w_draining;
  // Address/data are parked at zero outside DRAIN so reset values hold.
  assign o_mem_addr  = w_draining ? {i_head_waddr, r_byte_idx} : '0;
  assign o_mem_wdata = w_draining ? sb_byte(i_head_data, r_byte_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/dm_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dm_store_buffer                                        |
// | Description : Posted word-store buffer in front of a byte-wide data  |
// |               memory, with youngest-match load forwarding.           |
// |               Optional: STORE_COALESCE_EN merges a store into the    |
// |               youngest non-head entry at the same word address.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dm_store_buffer
  import dm_sb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dm_store_buffer_if.slave sb
);

  localparam int                 c_PTR_W   = $clog2(DEPTH);
  localparam int                 c_CNT_W   = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

  sb_entry_t             r_entry [DEPTH];
  logic [c_PTR_W-1:0]    r_head;
  logic [c_PTR_W-1:0]    r_tail;
  logic [c_PTR_W-1:0]    w_idx;
  logic [c_CNT_W-1:0]    r_count;
  logic [c_CNT_W-1:0]    w_count_nxt;
  logic [SB_WADDR_W-1:0] w_st_waddr;
  logic [SB_WADDR_W-1:0] w_ld_waddr;
  logic                  w_full;
  logic                  w_coal;
  logic                  w_push;
  logic                  w_alloc;
  logic                  w_pop;
  logic                  w_busy_nxt;
  logic                  w_fwd;
  logic [DATA_W-1:0]     w_ld_data;
  logic                  w_unused_addr_bits;

  assign w_st_waddr = sb.st_addr_i[ADDR_W-1:2];
  assign w_ld_waddr = sb.ld_addr_i[ADDR_W-1:2];
  // Byte offset and bits above the memory range are ignored by design.
  assign w_unused_addr_bits = ^{sb.st_addr_i[31:ADDR_W], sb.st_addr_i[1:0],
                                sb.ld_addr_i[31:ADDR_W], sb.ld_addr_i[1:0]};

  assign w_full = (r_count == c_DEPTH);

`ifdef STORE_COALESCE_EN
  logic [c_PTR_W-1:0] w_young;
  assign w_young = r_tail - c_PTR_ONE;
  // Only merge when the youngest entry is not the one being drained.
  assign w_coal  = (r_count >= c_CNT_W'(2)) && r_entry[w_young].valid &&
                   (r_entry[w_young].waddr == w_st_waddr);
`else
  assign w_coal  = 1'b0;
`endif

  // No look-ahead on a same-edge pop: a full buffer refuses new allocations.
  assign sb.st_ready_o = !w_full || w_coal;
  assign w_push        = sb.st_valid_i && sb.st_ready_o;
  assign w_alloc       = w_push && !w_coal;

  // Occupancy after this edge; also tells the drain FSM whether work remains.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_alloc, w_pop})
      2'b10:   w_count_nxt = r_count + c_CNT_W'(1);
      2'b01:   w_count_nxt = r_count - c_CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  assign w_busy_nxt = (w_count_nxt != '0);

  // FIFO storage: pop clears the head, allocation writes the tail.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
    end else begin
      if (w_pop) begin
        r_entry[r_head].valid <= 1'b0;
        r_head                <= r_head + c_PTR_ONE;
      end
      if (w_alloc) begin
        r_entry[r_tail] <= '{valid: 1'b1, waddr: w_st_waddr, data: sb.st_data_i};
        r_tail          <= r_tail + c_PTR_ONE;
      end
`ifdef STORE_COALESCE_EN
      if (w_push && w_coal) r_entry[w_young].data <= sb.st_data_i;
`endif
      r_count <= w_count_nxt;
    end
  end

  // Walk entries oldest to youngest so the youngest match overrides.
  always_comb begin
    w_ld_data = sb.ld_mem_data_i;
    w_fwd     = 1'b0;
    w_idx     = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + c_PTR_W'(i);
      if (r_entry[w_idx].valid && (r_entry[w_idx].waddr == w_ld_waddr)) begin
        w_ld_data = r_entry[w_idx].data;
        w_fwd     = 1'b1;
      end
    end
  end

  assign sb.ld_data_o = w_ld_data;
  assign sb.ld_fwd_o  = w_fwd;
  assign sb.count_o   = r_count;
  assign sb.empty_o   = (r_count == '0);

  dm_sb_drain_fsm #(
    .ADDR_W (ADDR_W)
  ) u_drain (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_busy_nxt   (w_busy_nxt),
    .i_head_waddr (r_entry[r_head].waddr),
    .i_head_data  (r_entry[r_head].data),
    .o_pop        (w_pop),
    .o_mem_we     (sb.mem_we_o),
    .o_mem_addr   (sb.mem_addr_o),
    .o_mem_wdata  (sb.mem_wdata_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_dm_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_dm_store_buffer                                     |
// | Description : Self-checking bench for dm_store_buffer against a      |
// |               queue-based reference model and program-order memory.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_dm_store_buffer;
  import dm_sb_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 7;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
`ifdef STORE_COALESCE_EN
  localparam int EXP_T5_COUNT = 2;
`else
  localparam int EXP_T5_COUNT = 3;
`endif

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] data;
  } st_t;

  logic clk_i;
  logic rst_i;

  dm_store_buffer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) sbif ();

  dm_store_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .sb    (sbif)
  );

  // Reference model: pending words in program order, drain byte position,
  // memory as written by the DUT, and memory as the program expects it.
  st_t        pend[$];
  logic [1:0] bidx;
  logic [7:0] tmem  [128];
  logic [7:0] pview [128];
  int         n_vec;
  int         n_fail;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] tm_word(input logic [31:0] a);
    return {tmem[{a[6:2], 2'd3}], tmem[{a[6:2], 2'd2}],
            tmem[{a[6:2], 2'd1}], tmem[{a[6:2], 2'd0}]};
  endfunction

  function automatic logic [31:0] pv_word(input logic [4:0] wa);
    return {pview[{wa, 2'd3}], pview[{wa, 2'd2}], pview[{wa, 2'd1}], pview[{wa, 2'd0}]};
  endfunction

  function automatic bit coal_hit(input logic [4:0] wa);
    bit en;
`ifdef STORE_COALESCE_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return en && (pend.size() >= 2) && (pend[pend.size()-1].wa == wa);
  endfunction

  function automatic logic [31:0] rnd_addr(input logic [4:0] wa);
    logic [31:0] r;
    r = $urandom();
    return {r[31:7], wa, r[1:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ld(input logic [31:0] a);
    sbif.ld_addr_i     = a;
    sbif.ld_mem_data_i = tm_word(a);
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle(output bit acc);
    logic [4:0] wa_st;
    logic [4:0] wa_ld;
    bit         rdy;
    bit         co;
    bit         fwd;
    bit         we;
    logic [6:0] wad;
    logic [7:0] wd;
    sbif.ld_mem_data_i = tm_word(sbif.ld_addr_i);
    @(negedge clk_i);
    wa_st = sbif.st_addr_i[6:2];
    wa_ld = sbif.ld_addr_i[6:2];
    co    = coal_hit(wa_st);
    rdy   = (pend.size() < DEPTH) || co;
    chk("st_ready", 32'(sbif.st_ready_o), 32'(rdy));
    chk("count", 32'(sbif.count_o), 32'(pend.size()));
    chk("empty", 32'(sbif.empty_o), 32'(pend.size() == 0));
    chk("mem_we", 32'(sbif.mem_we_o), 32'(pend.size() != 0));
    if (pend.size() != 0) begin
      chk("mem_addr", 32'(sbif.mem_addr_o), 32'({pend[0].wa, bidx}));
      chk("mem_wdata", 32'(sbif.mem_wdata_o), (pend[0].data >> (8 * bidx)) & 32'hFF);
    end
    fwd = 1'b0;
    foreach (pend[i]) if (pend[i].wa == wa_ld) fwd = 1'b1;
    chk("ld_fwd", 32'(sbif.ld_fwd_o), 32'(fwd));
    chk("ld_data", sbif.ld_data_o, pv_word(wa_ld));
    we  = sbif.mem_we_o;
    wad = sbif.mem_addr_o;
    wd  = sbif.mem_wdata_o;
    acc = sbif.st_valid_i && rdy;
    @(posedge clk_i);
    if (we) tmem[wad] = wd;
    if (pend.size() != 0) begin
      if (bidx == 2'd3) begin
        void'(pend.pop_front());
        bidx = 2'd0;
      end else begin
        bidx = bidx + 2'd1;
      end
    end
    if (acc) begin
      for (int b = 0; b < 4; b++) pview[{wa_st, 2'(b)}] = 8'(sbif.st_data_i >> (8 * b));
      if (co) pend[pend.size()-1].data = sbif.st_data_i;
      else    pend.push_back('{wa: wa_st, data: sbif.st_data_i});
    end
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, output bit acc);
    sbif.st_valid_i = 1'b1;
    sbif.st_addr_i  = a;
    sbif.st_data_i  = d;
    cycle(acc);
  endtask

  task automatic drain_all();
    bit a;
    sbif.st_valid_i = 1'b0;
    for (int k = 0; (k < 6 * DEPTH) && (pend.size() != 0); k++) cycle(a);
    cycle(a);
  endtask

  initial begin
    bit          a;
    int          rej;
    int          tries;
    logic [31:0] d5 [5];
    logic [7:0]  old2;
    logic [7:0]  old3;

    n_vec  = 0;
    n_fail = 0;
    bidx   = 2'd0;
    rst_i  = 1'b0;
    sbif.st_valid_i = 1'b0;
    sbif.st_addr_i  = '0;
    sbif.st_data_i  = '0;
    for (int i = 0; i < 128; i++) begin
      tmem[i]  = 8'($urandom());
      pview[i] = tmem[i];
    end
    set_ld(32'd0);

    // Reset values.
    @(negedge clk_i);
    chk("rst_ready", 32'(sbif.st_ready_o), 32'd1);
    chk("rst_fwd", 32'(sbif.ld_fwd_o), 32'd0);
    chk("rst_we", 32'(sbif.mem_we_o), 32'd0);
    chk("rst_addr", 32'(sbif.mem_addr_o), 32'd0);
    chk("rst_wdata", 32'(sbif.mem_wdata_o), 32'd0);
    chk("rst_count", 32'(sbif.count_o), 32'd0);
    chk("rst_empty", 32'(sbif.empty_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Single store, drained little-endian over the next four cycles.
    set_ld(32'd8);
    put(32'h0000_0008, 32'h1122_3344, a);
    sbif.st_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) cycle(a);
    chk("t1_b8", 32'(tmem[8]), 32'h44);
    chk("t1_b9", 32'(tmem[9]), 32'h33);
    chk("t1_b10", 32'(tmem[10]), 32'h22);
    chk("t1_b11", 32'(tmem[11]), 32'h11);
    chk("t1_empty", 32'(sbif.empty_o), 32'd1);

    // Five back-to-back stores: fifth waits for the first pop, no look-ahead.
    rej = 0;
    for (int i = 0; i < 5; i++) begin
      d5[i] = $urandom();
      tries = 0;
      do begin
        put(32'h20 + 32'(4 * i), d5[i], a);
        if (!a && (i == 4)) rej++;
        tries++;
      end while (!a && (tries < 10));
    end
    chk("t2_rejects", 32'(rej), 32'd1);
    drain_all();
    for (int i = 0; i < 20; i++)
      chk("t2_mem", 32'(tmem[32 + i]), (d5[i / 4] >> (8 * (i % 4))) & 32'hFF);

    // Forwarding during drain and pass-through on a miss.
    put(32'h0000_0010, 32'hAABB_CCDD, a);
    sbif.st_valid_i = 1'b0;
    set_ld(32'd16);
    #1;
    chk("t3_fwd16", 32'(sbif.ld_fwd_o), 32'd1);
    chk("t3_ld16", sbif.ld_data_o, 32'hAABB_CCDD);
    set_ld(32'd20);
    #1;
    chk("t3_fwd20", 32'(sbif.ld_fwd_o), 32'd0);
    chk("t3_ld20", sbif.ld_data_o, tm_word(32'd20));
    drain_all();

    // Same-address stores: youngest wins; merge only past the head entry.
    put(32'h4, 32'd1, a);
    put(32'h4, 32'd2, a);
    put(32'h4, 32'd3, a);
    sbif.st_valid_i = 1'b0;
    set_ld(32'd4);
    #1;
    chk("t4_ld4", sbif.ld_data_o, 32'd3);
    chk("t4_count", 32'(sbif.count_o), 32'(EXP_T5_COUNT));
    drain_all();

    // Asynchronous reset with byte 2 of a word about to be written.
    old2 = tmem[66];
    old3 = tmem[67];
    put(32'h0000_0040, 32'hDEAD_BEEF, a);
    sbif.st_valid_i = 1'b0;
    cycle(a);
    cycle(a);
    rst_i = 1'b0;
    #1;
    chk("t5_we", 32'(sbif.mem_we_o), 32'd0);
    chk("t5_count", 32'(sbif.count_o), 32'd0);
    chk("t5_empty", 32'(sbif.empty_o), 32'd1);
    chk("t5_ready", 32'(sbif.st_ready_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    chk("t5_b64", 32'(tmem[64]), 32'hEF);
    chk("t5_b65", 32'(tmem[65]), 32'hBE);
    chk("t5_b66", 32'(tmem[66]), 32'(old2));
    chk("t5_b67", 32'(tmem[67]), 32'(old3));
    pend.delete();
    bidx = 2'd0;
    for (int i = 0; i < 128; i++) pview[i] = tmem[i];
    @(posedge clk_i);
    #1;
    cycle(a);

    // Random traffic over a small address window to force hits and wraps.
    for (int k = 0; k < 400; k++) begin
      sbif.st_valid_i = ($urandom_range(0, 99) < 60);
      sbif.st_addr_i  = rnd_addr(5'($urandom_range(0, 7)));
      sbif.st_data_i  = $urandom();
      sbif.ld_addr_i  = rnd_addr(5'($urandom_range(0, 7)));
      cycle(a);
    end
    drain_all();
    chk("final_empty", 32'(sbif.empty_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
